// File: rtl/mac_share_sched_pkg.sv
// Shared definitions for the mac_share_sched block.
//   MAC_*_DEF  : default parameter values for the scheduler and its interface
//   MAC_NREQ_MAX : widest request vector rr_pick can search (NREQ must not exceed it)
//   s1_t       : layout of the stage-1 pipeline register at default widths
//   rr_pick    : round-robin grant index for a request vector and start pointer
package mac_pkg;

  localparam int MAC_WIDTH_DEF = 4;
  localparam int MAC_NREQ_DEF  = 2;
  localparam int MAC_IDW_DEF   = 1;
  localparam int MAC_NREQ_MAX  = 32;

  // mac_pipe declares the same field layout at its own parameter widths.
  typedef struct packed {
    logic                     v;
    logic [MAC_IDW_DEF-1:0]   id;
    logic [MAC_WIDTH_DEF-1:0] prod;
    logic [MAC_WIDTH_DEF-1:0] c;
  } s1_t;

  // First set bit of valid searching ptr, ptr+1, ... (mod nreq). Walking the
  // offsets from highest to lowest lets the nearest hit overwrite the others.
  // Returns 0 when nothing is valid; callers qualify with the valid bit.
  function automatic int rr_pick(input logic [MAC_NREQ_MAX-1:0] valid,
                                 input int ptr, input int nreq);
    int idx;
    rr_pick = 0;
    for (int k = MAC_NREQ_MAX - 1; k >= 0; k--) begin
      if (k < nreq) begin
        idx = (ptr + k) % nreq;
        if (valid[idx]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/mac_share_sched_if.sv
// Request/response bundle of mac_share_sched.
//   req_valid/req_ready : per-requester handshake, one bit per requester
//   req_a/req_b/req_c   : operands, requester i owns slice [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready : single result handshake to the consumer
//   rsp_id/rsp_data     : issuing requester and (a*b+c) mod 2**WIDTH
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both 1; the sender keeps its payload stable while
// valid is high and not yet accepted (requesters may withdraw valid instead).
interface mac_share_sched_if
  import mac_pkg::*;
#(
  parameter int WIDTH = MAC_WIDTH_DEF,
  parameter int NREQ  = MAC_NREQ_DEF,
  parameter int IDW   = MAC_IDW_DEF
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*WIDTH-1:0] req_c;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;

  // master: requesters + result consumer; slave: the scheduler
  modport master (
    output req_valid, req_a, req_b, req_c, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );
  modport slave (
    input  req_valid, req_a, req_b, req_c, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/mac_share_sched_pipe.sv
// mac_pipe: two-stage multiply-then-add datapath, no arbitration state.
//   clk, rst_n          : clock, synchronous active-low reset
//   s1_en, s2_en        : load enables for stage 1 and stage 2 (output stage)
//   in_v, in_id         : operand-valid and requester id entering stage 1
//   in_a, in_b, in_c    : selected operands
//   s1_v                : stage 1 holds a live op
//   rsp_valid/id/data   : registered output stage
module mac_pipe #(
  parameter int WIDTH = 4,
  parameter int IDW   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s1_en,
  input  logic             s2_en,
  input  logic             in_v,
  input  logic [IDW-1:0]   in_id,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  output logic             s1_v,
  output logic             rsp_valid,
  output logic [IDW-1:0]   rsp_id,
  output logic [WIDTH-1:0] rsp_data
);

  typedef struct packed {
    logic             v;
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] c;
  } s1_t;

  s1_t              s1;
  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] sum;

  // Both results are sized to WIDTH, so the mod 2**WIDTH wrap is implicit.
  assign prod = in_a * in_b;
  assign sum  = s1.prod + s1.c;
  assign s1_v = s1.v;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1        <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      if (s1_en) begin
        s1.v    <= in_v;
        s1.id   <= in_id;
        s1.prod <= prod;
        s1.c    <= in_c;
      end
      if (s2_en) begin
        rsp_valid <= s1.v;
        rsp_id    <= s1.id;
        rsp_data  <= sum;
      end
    end
  end

endmodule

// File: rtl/mac_share_sched.sv
// mac_share_sched: round-robin scheduler sharing one pipelined a*b+c unit
// among NREQ requesters.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : mac_share_sched_if slave (per-requester operands in, tagged result out)
// Holds the arbiter, the round-robin pointer, the stage enables and the
// operand mux; the arithmetic lives in mac_pipe.
module mac_share_sched
  import mac_pkg::*;
#(
  parameter int WIDTH = MAC_WIDTH_DEF,
  parameter int NREQ  = MAC_NREQ_DEF,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mac_share_sched_if.slave      bus
);

  logic [IDW-1:0]   gnt;
  logic [IDW-1:0]   rr_ptr;
  logic             s1_v;
  logic             s1_en;
  logic             s2_en;
  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] op_c;

  // Output stage advances when empty or being drained; stage 1 advances when
  // empty or when it can move forward, which lets a bubble collapse under
  // backpressure.
  assign s2_en = !bus.rsp_valid || bus.rsp_ready;
  assign s1_en = !s1_v || s2_en;

  // Grant depends only on valids and the pointer, never on result data.
  always_comb begin
    gnt           = IDW'(rr_pick(MAC_NREQ_MAX'(bus.req_valid), int'(rr_ptr), NREQ));
    bus.req_ready = '0;
    if (rst_n && s1_en) bus.req_ready[gnt] = bus.req_valid[gnt];
  end

  assign accept = |(bus.req_valid & bus.req_ready);

  assign op_a = bus.req_a[gnt*WIDTH +: WIDTH];
  assign op_b = bus.req_b[gnt*WIDTH +: WIDTH];
  assign op_c = bus.req_c[gnt*WIDTH +: WIDTH];

  // Pointer moves past the winner only on an actual transfer, so a requester
  // that withdraws valid does not cost anyone their turn.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
    end
  end

  mac_pipe #(
    .WIDTH (WIDTH),
    .IDW   (IDW)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .s1_en     (s1_en),
    .s2_en     (s2_en),
    .in_v      (accept),
    .in_id     (gnt),
    .in_a      (op_a),
    .in_b      (op_b),
    .in_c      (op_c),
    .s1_v      (s1_v),
    .rsp_valid (bus.rsp_valid),
    .rsp_id    (bus.rsp_id),
    .rsp_data  (bus.rsp_data)
  );

endmodule

// File: tb/tb_mac_share_sched.sv
// Testbench for mac_share_sched. Inputs change 1 time unit after a rising
// edge; handshakes and outputs are observed on the falling edge.
module tb_mac_share_sched;

  localparam int WIDTH = 4;
  localparam int NREQ  = 2;
  localparam int IDW   = 1;
  localparam int W     = IDW + WIDTH;

  logic clk;
  logic rst_n;

  mac_share_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

  mac_share_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int checks = 0;
  int passes = 0;
  int rsp_cnt = 0;
  int acc_cnt = 0;
  int max_wait = 0;
  int wait_cnt [NREQ];
  logic [W-1:0] exp_q [$];

  logic [WIDTH-1:0] m_a, m_b, m_c, m_e;
  logic [W-1:0]     m_got, m_exp;
  logic             m_any;

  // Expected {id,data} is pushed for every accepted op and popped for every
  // delivered response; a reset discards whatever was in flight.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    end else begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        rsp_cnt++;
        checks++;
        m_got = {bus.rsp_id, bus.rsp_data};
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected_rsp got id=%0d data=%0d, none outstanding",
                   bus.rsp_id, bus.rsp_data);
        end else begin
          m_exp = exp_q.pop_front();
          if (m_got !== m_exp)
            $display("FAIL sb_rsp got id=%0d data=%0d exp id=%0d data=%0d",
                     m_got[W-1 -: IDW], m_got[WIDTH-1:0], m_exp[W-1 -: IDW], m_exp[WIDTH-1:0]);
          else passes++;
        end
      end
      m_any = |(bus.req_valid & bus.req_ready);
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          m_a = bus.req_a[i*WIDTH +: WIDTH];
          m_b = bus.req_b[i*WIDTH +: WIDTH];
          m_c = bus.req_c[i*WIDTH +: WIDTH];
          m_e = m_a * m_b + m_c;
          exp_q.push_back({IDW'(i), m_e});
          acc_cnt++;
        end
        if (!bus.req_valid[i] || bus.req_ready[i]) wait_cnt[i] = 0;
        else if (m_any) begin
          wait_cnt[i]++;
          if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_op(input int i, input logic [WIDTH-1:0] a, b, c, output bit ok);
    ok = 1'b0;
    bus.req_a[i*WIDTH +: WIDTH] = a;
    bus.req_b[i*WIDTH +: WIDTH] = b;
    bus.req_c[i*WIDTH +: WIDTH] = c;
    bus.req_valid[i] = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (bus.req_ready[i]) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(output bit got, output logic [IDW-1:0] id, output logic [WIDTH-1:0] d);
    got = 1'b0; id = '0; d = '0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus.rsp_valid && bus.rsp_ready) begin
        got = 1'b1; id = bus.rsp_id; d = bus.rsp_data;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = '1;
    bus.req_a = '0; bus.req_b = '0; bus.req_c = '0;
    bus.rsp_ready = 1'b1;
    idle(2);
    checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); else passes++;
    checks++; if (bus.rsp_data !== '0) $display("FAIL reset_rsp_data got=%0d exp=0", bus.rsp_data); else passes++;
    checks++; if (bus.rsp_id !== '0) $display("FAIL reset_rsp_id got=%0d exp=0", bus.rsp_id); else passes++;
    checks++; if (bus.req_ready !== '0) $display("FAIL reset_req_ready got=%b exp=00", bus.req_ready); else passes++;
    bus.req_valid = '0;
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_single();
    bit ok;
    bus.rsp_ready = 1'b1;
    send_op(0, 4'd3, 4'd5, 4'd2, ok);
    checks++; if (!ok) $display("FAIL single_accept got=0 exp=1"); else passes++;
    checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL single_early got=%b exp=0", bus.rsp_valid); else passes++;
    idle(1);
    checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", bus.rsp_valid); else passes++;
    checks++; if (bus.rsp_id !== 1'b0) $display("FAIL single_id got=%0d exp=0", bus.rsp_id); else passes++;
    checks++; if (bus.rsp_data !== 4'd1) $display("FAIL single_data got=%0d exp=1", bus.rsp_data); else passes++;
    idle(1);
    checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL single_dup got=%b exp=0", bus.rsp_valid); else passes++;
  endtask

  task automatic test_wrap();
    bit ok, got;
    logic [IDW-1:0] id;
    logic [WIDTH-1:0] d;
    send_op(1, 4'd15, 4'd15, 4'd15, ok);
    wait_rsp(got, id, d);
    checks++; if (!(ok && got)) $display("FAIL wrap1_handshake got=%b%b exp=11", ok, got); else passes++;
    checks++; if (id !== 1'b1 || d !== 4'd0) $display("FAIL wrap1_rsp got id=%0d data=%0d exp id=1 data=0", id, d); else passes++;
    send_op(1, 4'd0, 4'd9, 4'd7, ok);
    wait_rsp(got, id, d);
    checks++; if (!(ok && got)) $display("FAIL wrap2_handshake got=%b%b exp=11", ok, got); else passes++;
    checks++; if (id !== 1'b1 || d !== 4'd7) $display("FAIL wrap2_rsp got id=%0d data=%0d exp id=1 data=7", id, d); else passes++;
  endtask

  task automatic test_contention();
    logic [NREQ-1:0] exp_rdy;
    bus.rsp_ready = 1'b1;
    bus.req_a = NREQ*WIDTH'($urandom); bus.req_b = NREQ*WIDTH'($urandom); bus.req_c = NREQ*WIDTH'($urandom);
    bus.req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (bus.req_ready !== exp_rdy) $display("FAIL contend_gnt%0d got=%b exp=%b", k, bus.req_ready, exp_rdy); else passes++;
      if (k >= 2) begin
        checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL contend_rate%0d got=%b exp=1", k, bus.rsp_valid); else passes++;
      end
      @(posedge clk); #1;
      bus.req_a = NREQ*WIDTH'($urandom); bus.req_b = NREQ*WIDTH'($urandom); bus.req_c = NREQ*WIDTH'($urandom);
    end
    bus.req_valid = '0;
    idle(4);
    checks++; if (exp_q.size() != 0) $display("FAIL contend_drain got=%0d outstanding exp=0", exp_q.size()); else passes++;
  endtask

  task automatic test_backpressure();
    logic [3:0] rdy_seen;
    logic [W-1:0] held;
    int base;
    rdy_seen = '0; held = '0;
    bus.rsp_ready = 1'b0;
    bus.req_a[WIDTH-1:0] = WIDTH'($urandom);
    bus.req_b[WIDTH-1:0] = WIDTH'($urandom);
    bus.req_c[WIDTH-1:0] = WIDTH'($urandom);
    bus.req_valid = 2'b01;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rdy_seen[k] = bus.req_ready[0];
      if (k == 2) held = {bus.rsp_id, bus.rsp_data};
      if (k == 3) begin
        checks++; if ({bus.rsp_id, bus.rsp_data} !== held) $display("FAIL bp_stable got=%h exp=%h", {bus.rsp_id, bus.rsp_data}, held); else passes++;
      end
      if (k >= 2) begin
        checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL bp_valid%0d got=%b exp=1", k, bus.rsp_valid); else passes++;
      end
      @(posedge clk); #1;
      if (rdy_seen[k]) begin
        bus.req_a[WIDTH-1:0] = WIDTH'($urandom);
        bus.req_b[WIDTH-1:0] = WIDTH'($urandom);
        bus.req_c[WIDTH-1:0] = WIDTH'($urandom);
      end
    end
    checks++; if (rdy_seen !== 4'b0011) $display("FAIL bp_ready_pattern got=%b exp=0011", rdy_seen); else passes++;
    bus.req_valid = '0;
    base = rsp_cnt;
    bus.rsp_ready = 1'b1;
    idle(5);
    checks++; if (rsp_cnt - base != 2) $display("FAIL bp_drain_count got=%0d exp=2", rsp_cnt - base); else passes++;
    checks++; if (exp_q.size() != 0) $display("FAIL bp_outstanding got=%0d exp=0", exp_q.size()); else passes++;
  endtask

  task automatic test_reset_midop();
    bit ok;
    int seen;
    bus.rsp_ready = 1'b1;
    send_op(0, 4'd2, 4'd3, 4'd4, ok);
    checks++; if (!ok) $display("FAIL midrst_accept got=0 exp=1"); else passes++;
    rst_n = 1'b0;
    idle(2);
    checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL midrst_valid got=%b exp=0", bus.rsp_valid); else passes++;
    checks++; if (dut.rr_ptr !== '0) $display("FAIL midrst_ptr got=%0d exp=0", dut.rr_ptr); else passes++;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen != 0) $display("FAIL midrst_flushed got=%0d rsp exp=0", seen); else passes++;
    bus.req_valid = '1;
    @(negedge clk);
    checks++; if (bus.req_ready !== 2'b01) $display("FAIL midrst_first_gnt got=%b exp=01", bus.req_ready); else passes++;
    @(posedge clk); #1;
    bus.req_valid = '0;
    idle(4);
  endtask

  task automatic test_random();
    int target, cyc;
    target = acc_cnt + 10000;
    max_wait = 0;
    cyc = 0;
    while (acc_cnt < target && cyc < 60000) begin
      for (int i = 0; i < NREQ; i++) bus.req_valid[i] = ($urandom_range(0, 3) != 0);
      bus.req_a = NREQ*WIDTH'($urandom);
      bus.req_b = NREQ*WIDTH'($urandom);
      bus.req_c = NREQ*WIDTH'($urandom);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (acc_cnt < target) $display("FAIL rand_budget got=%0d accepts exp=%0d", acc_cnt, target); else passes++;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    idle(6);
    checks++; if (exp_q.size() != 0) $display("FAIL rand_outstanding got=%0d exp=0", exp_q.size()); else passes++;
    checks++; if (max_wait > NREQ) $display("FAIL rand_starvation got=%0d exp<=%0d", max_wait, NREQ); else passes++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_contention();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
